// File: rtl/breath_led_cfg_arb.sv
// Round-robin arbiter that shares the breathing-LED rate-setting port among NUM_REQ requesters.
// Optional AUTO_SWEEP_EN adds an idle-time auto-sweep of the step through the same update path.
module breath_led_cfg_arb #(
  parameter int          NUM_REQ         = 3,
  parameter int          HOLD_CYCLES     = 16,
  parameter logic [9:0]  START_FREQ_STEP = 10'd1,
  parameter int          SWEEP_IDLE      = 1000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [10*NUM_REQ-1:0] req_step,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  set_en,
  output logic [9:0]            set_freq_step,
  output logic                  busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be 2..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (SWEEP_IDLE < 2) begin : g_bad_sweep
    $error("SWEEP_IDLE must be >= 2");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     rr_ptr, rr_n;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic              set_en_n, busy_n;
  logic [9:0]        step_n;

  logic [9:0]        steps [NUM_REQ];
  logic              found;
  logic [PW-1:0]     win;
  logic [PW:0]       sum;

  function automatic logic [9:0] clamp_step(input logic [9:0] s);
    if (s == 10'd0)
      return 10'd1;
    else if (s >= 10'd10)
      return 10'd10;
    else
      return s;
  endfunction

  // First set request at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      steps[i] = req_step[i*10 +: 10];
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      if (!found && req[sum[PW-1:0]]) begin
        found = 1'b1;
        win   = sum[PW-1:0];
      end
    end
  end

`ifdef AUTO_SWEEP_EN
  localparam int IW = $clog2(SWEEP_IDLE);

  logic [IW-1:0] idle_cnt, idle_n;
  logic          sweep_req, sweep_req_n;
  logic          dir_up, dir_n;
  logic          up_eff;
  logic [9:0]    sweep_step;

  // Direction turns around at the ends even if a grant parked the step there.
  always_comb begin
    up_eff     = dir_up ? (set_freq_step < 10'd10) : (set_freq_step <= 10'd1);
    sweep_step = up_eff ? set_freq_step + 10'd1 : set_freq_step - 10'd1;
  end
`endif

  always_comb begin
    state_n  = state;
    gnt_n    = '0;
    set_en_n = 1'b0;
    step_n   = set_freq_step;
    rr_n     = rr_ptr;
    hold_n   = hold_cnt;
    busy_n   = busy;
`ifdef AUTO_SWEEP_EN
    idle_n      = '0;
    sweep_req_n = 1'b0;
    dir_n       = dir_up;
`endif
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (found) begin
          gnt_n[win] = 1'b1;
          set_en_n   = 1'b1;
          step_n     = clamp_step(steps[win]);
          rr_n       = (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
          hold_n     = HW'(HOLD_CYCLES-1);
          busy_n     = 1'b1;
          state_n    = HOLD;
        end
`ifdef AUTO_SWEEP_EN
        else if (sweep_req) begin
          set_en_n = 1'b1;
          step_n   = sweep_step;
          dir_n    = (sweep_step >= 10'd10) ? 1'b0 :
                     (sweep_step <= 10'd1)  ? 1'b1 : up_eff;
          hold_n   = HW'(HOLD_CYCLES-1);
          busy_n   = 1'b1;
          state_n  = HOLD;
        end else if (idle_cnt == IW'(SWEEP_IDLE-1)) begin
          sweep_req_n = 1'b1;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          hold_n = hold_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      hold_cnt      <= '0;
      gnt           <= '0;
      set_en        <= 1'b0;
      set_freq_step <= START_FREQ_STEP;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      rr_ptr        <= rr_n;
      hold_cnt      <= hold_n;
      gnt           <= gnt_n;
      set_en        <= set_en_n;
      set_freq_step <= step_n;
      busy          <= busy_n;
    end
  end

`ifdef AUTO_SWEEP_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idle_cnt  <= '0;
      sweep_req <= 1'b0;
      dir_up    <= 1'b1;
    end else begin
      idle_cnt  <= idle_n;
      sweep_req <= sweep_req_n;
      dir_up    <= dir_n;
    end
  end
`endif

endmodule

// File: tb/tb_breath_led_cfg_arb.sv
// Self-checking bench for breath_led_cfg_arb: directed scenarios plus a randomized run
// compared against a cycle-count reference model of the arbitration rules.
module tb_breath_led_cfg_arb;

  localparam int N    = 3;
  localparam int HOLD = 16;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic [N-1:0]   req;
  logic [10*N-1:0] req_step;
  logic [N-1:0]   gnt;
  logic           set_en;
  logic [9:0]     set_freq_step;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;

  breath_led_cfg_arb #(
    .NUM_REQ(N), .HOLD_CYCLES(HOLD), .START_FREQ_STEP(10'd1), .SWEEP_IDLE(1000)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .req_step(req_step),
    .gnt(gnt), .set_en(set_en), .set_freq_step(set_freq_step), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset;
    sys_rst  = 1'b1;
    req      = '0;
    req_step = '0;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  function automatic logic [9:0] clamp_ref(input int s);
    if (s == 0) return 10'd1;
    if (s >= 10) return 10'd10;
    return 10'(s);
  endfunction

  task automatic test_reset;
    do_reset();
    tick();
    vectors++; if (set_freq_step !== 10'd1) begin miscompares++; $display("[TB] FAIL reset_step: got %0d expected 1", set_freq_step); end
    vectors++; if (set_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_set_en: got %b expected 0", set_en); end
    vectors++; if (gnt !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_gnt: got %b expected 000", gnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    int busy_cycles;
    int pulses;
    do_reset();
    req_step[9:0] = 10'd5;
    req = 3'b001;
    vectors++; if (set_en !== 1'b0) begin miscompares++; $display("[TB] FAIL single_latency: got set_en %b expected 0 before edge", set_en); end
    tick();
    vectors++; if (set_en !== 1'b1) begin miscompares++; $display("[TB] FAIL single_set_en: got %b expected 1", set_en); end
    vectors++; if (gnt !== 3'b001) begin miscompares++; $display("[TB] FAIL single_gnt: got %b expected 001", gnt); end
    vectors++; if (set_freq_step !== 10'd5) begin miscompares++; $display("[TB] FAIL single_step: got %0d expected 5", set_freq_step); end
    busy_cycles = busy ? 1 : 0;
    pulses = 0;
    req = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) busy_cycles++;
      if (set_en) pulses++;
    end
    vectors++; if (busy_cycles !== HOLD) begin miscompares++; $display("[TB] FAIL single_busy_len: got %0d expected %0d", busy_cycles, HOLD); end
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL single_extra_pulse: got %0d expected 0", pulses); end
    vectors++; if (set_freq_step !== 10'd5) begin miscompares++; $display("[TB] FAIL single_step_hold: got %0d expected 5", set_freq_step); end
  endtask

  task automatic test_clamp;
    int vals [8] = '{0, 600, 7, 10, 9, 1023, 1, 11};
    do_reset();
    for (int j = 0; j < 8; j++) begin
      req_step[19:10] = 10'(vals[j]);
      req = 3'b010;
      for (int t = 0; t < 40 && !set_en; t++) tick();
      vectors++;
      if (!set_en) begin
        miscompares++; $display("[TB] FAIL clamp_timeout: got no set_en expected one for step %0d", vals[j]);
      end else begin
        if (set_freq_step !== clamp_ref(vals[j]) || gnt !== 3'b010) begin
          miscompares++;
          $display("[TB] FAIL clamp_%0d: got step %0d gnt %b expected step %0d gnt 010", vals[j], set_freq_step, gnt, clamp_ref(vals[j]));
        end
      end
      req = 3'b000;
      repeat (HOLD + 1) tick();
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] seq [4];
    int at [4];
    logic [N-1:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int n;
    do_reset();
    req_step = {10'd3, 10'd6, 10'd9};
    req = 3'b111;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      tick();
      if (set_en) begin seq[n] = gnt; at[n] = c; n++; end
    end
    req = 3'b000;
    vectors++; if (n !== 4) begin miscompares++; $display("[TB] FAIL rr_count: got %0d grants expected 4", n); end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (seq[i] !== exp_seq[i]) begin miscompares++; $display("[TB] FAIL rr_gnt%0d: got %b expected %b", i, seq[i], exp_seq[i]); end
      if (i > 0) begin
        vectors++;
        if (at[i] - at[i-1] !== HOLD + 1) begin miscompares++; $display("[TB] FAIL rr_spacing%0d: got %0d expected %0d", i, at[i] - at[i-1], HOLD + 1); end
      end
    end
    repeat (HOLD + 1) tick();
  endtask

  task automatic test_withdraw;
    int pulses;
    do_reset();
    req_step = {10'd4, 10'd5, 10'd6};
    req = 3'b111;
    tick();
    vectors++; if (gnt !== 3'b001) begin miscompares++; $display("[TB] FAIL wd_first: got %b expected 001", gnt); end
    req[0] = 1'b0;
    repeat (3) tick();
    req[2] = 1'b0;
    for (int t = 0; t < 40 && !set_en; t++) tick();
    vectors++; if (set_en !== 1'b1 || gnt !== 3'b010) begin miscompares++; $display("[TB] FAIL wd_second: got set_en %b gnt %b expected 1 010", set_en, gnt); end
    req = 3'b000;
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (set_en || gnt != 3'b000) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL wd_no_grant: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_reset_mid_hold;
    do_reset();
    req_step[9:0] = 10'd3;
    req = 3'b001;
    tick();
    req = 3'b000;
    repeat (10) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    sys_rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy_async: got %b expected 0", busy); end
    vectors++; if (set_freq_step !== 10'd1) begin miscompares++; $display("[TB] FAIL mid_step_async: got %0d expected 1", set_freq_step); end
    req = 3'b110;
    req_step = {10'd8, 10'd4, 10'd0};
    tick();
    sys_rst = 1'b0;
    tick();
    vectors++; if (gnt !== 3'b010 || set_freq_step !== 10'd4) begin miscompares++; $display("[TB] FAIL mid_regrant: got gnt %b step %0d expected 010 4", gnt, set_freq_step); end
    req = 3'b000;
    repeat (HOLD + 1) tick();
  endtask

  task automatic test_random;
    logic [N-1:0] exp_gnt;
    logic         exp_en;
    logic [9:0]   exp_step;
    logic         exp_busy;
    logic         pending [N];
    int           pstep [N];
    int           ptr, last_s, win;
    logic         have_s, idle;
    do_reset();
    exp_gnt = '0; exp_en = 1'b0; exp_step = 10'd1; exp_busy = 1'b0;
    ptr = 0; last_s = 0; have_s = 1'b0;
    for (int i = 0; i < N; i++) begin pending[i] = 1'b0; pstep[i] = 0; end
    for (int c = 0; c < 800; c++) begin
      vectors++; if (gnt !== exp_gnt) begin miscompares++; $display("[TB] FAIL rand_gnt@%0d: got %b expected %b", c, gnt, exp_gnt); end
      vectors++; if (set_en !== exp_en) begin miscompares++; $display("[TB] FAIL rand_set_en@%0d: got %b expected %b", c, set_en, exp_en); end
      vectors++; if (set_freq_step !== exp_step) begin miscompares++; $display("[TB] FAIL rand_step@%0d: got %0d expected %0d", c, set_freq_step, exp_step); end
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("[TB] FAIL rand_busy@%0d: got %b expected %b", c, busy, exp_busy); end
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) pending[i] = 1'b0;
        else if (pending[i] && $urandom_range(0, 19) == 0) pending[i] = 1'b0;
        else if (!pending[i] && $urandom_range(0, 3) == 0) begin
          pending[i] = 1'b1;
          case ($urandom_range(0, 3))
            0: pstep[i] = 0;
            1: pstep[i] = $urandom_range(1, 12);
            2: pstep[i] = $urandom_range(0, 1023);
            default: pstep[i] = 10;
          endcase
        end
        req[i] = pending[i];
        req_step[i*10 +: 10] = pending[i] ? 10'(pstep[i]) : 10'($urandom_range(0, 1023));
      end
      idle = !have_s || (c >= last_s + HOLD);
      exp_gnt = '0;
      exp_en  = 1'b0;
      if (idle && req != '0) begin
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && req[(ptr + k) % N]) win = (ptr + k) % N;
        exp_gnt  = 3'(1 << win);
        exp_en   = 1'b1;
        exp_step = clamp_ref(pstep[win]);
        last_s   = c + 1;
        have_s   = 1'b1;
        ptr      = (win + 1) % N;
      end
      exp_busy = have_s && ((c + 1 - last_s) < HOLD);
      tick();
    end
    req = '0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst  = 1'b1;
    req      = '0;
    req_step = '0;
    test_reset();
    test_single();
    test_clamp();
    test_round_robin();
    test_withdraw();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
